// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Bit positions inside the held-key vector.
    localparam int KEY_W  = 0;
    localparam int KEY_A  = 1;
    localparam int KEY_S  = 2;
    localparam int KEY_D  = 3;
    localparam int KEY_ST = 4;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchroniser, clock glitch filter, frame FSM and
// in-frame timeout. Produces registered byte/valid/error plus a same-cycle strobe.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic [7:0] byte_data,
    output logic       byte_done
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_s;
    logic                   data_s;
    logic                   filt_r;
    logic [FW-1:0]          filt_cnt_r;
    logic                   fall_s;
    logic [TW-1:0]          tmo_cnt_r;
    logic                   tmo_hit_s;

    frame_state_e state_r, state_n;
    logic [2:0]   bit_cnt_r, bit_cnt_n;
    logic [7:0]   shift_r, shift_n;
    logic         par_r, par_n;
    logic [7:0]   code_r, code_n;
    logic         valid_r, valid_n;
    logic         err_r, err_n;

    // Synchronise both pins; reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r  <= '1;
            data_sync_r <= '1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_r[SYNC_STAGES-1];
    assign data_s = data_sync_r[SYNC_STAGES-1];

    // Filtered clock follows the synced clock only after FILTER_LEN stable cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_r     <= 1'b1;
            filt_cnt_r <= '0;
        end else if (clk_s != filt_r) begin
            if (filt_cnt_r == FILT_LAST) begin
                filt_r     <= clk_s;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FW'(1);
            end
        end else begin
            filt_cnt_r <= '0;
        end
    end

    // Edge is flagged in the cycle the filter commits to low, so data is sampled then.
    assign fall_s = filt_r & ~clk_s & (filt_cnt_r == FILT_LAST);

    // Idle-time counter, only running while a frame is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (fall_s || (state_r == ST_IDLE)) begin
            tmo_cnt_r <= '0;
        end else if (tmo_cnt_r != TMO_LAST) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign tmo_hit_s = (state_r != ST_IDLE) && !fall_s && (tmo_cnt_r == TMO_LAST);

    // Frame FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
            code_r    <= 8'h00;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            par_r     <= par_n;
            code_r    <= code_n;
            valid_r   <= valid_n;
            err_r     <= err_n;
        end
    end

    // Frame FSM next state: advances only on filtered falling edges or timeout.
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        par_n     = par_r;
        code_n    = code_r;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (tmo_hit_s) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 3'd0;
            shift_n   = 8'h00;
            err_n     = 1'b1;
        end else if (fall_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = 3'd0;
                        shift_n   = 8'h00;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_n = {data_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_n = ST_PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt_r + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_n   = data_s;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (data_s && parity_ok(shift_r, par_r)) begin
                        code_n  = shift_r;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    assign scan_code  = code_r;
    assign scan_valid = valid_r;
    assign frame_err  = err_r;
    assign byte_data  = shift_r;
    assign byte_done  = valid_n;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to held-key levels for the tank game (W/A/S/D/space).
// Optional PS2_ARROW_KEYS_EN maps E0-prefixed arrow keys onto the same outputs.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       key_w,
    output logic       key_a,
    output logic       key_s,
    output logic       key_d,
    output logic       key_st
);

    logic [7:0] byte_data_s;
    logic       byte_done_s;
    logic       brk_r, brk_n;
    logic       ext_r, ext_n;
    logic [4:0] keys_r, keys_n;

    ps2_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err),
        .byte_data  (byte_data_s),
        .byte_done  (byte_done_s)
    );

    // Prefix flags and held key levels; updated on the same edge that raises scan_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_r  <= 1'b0;
            ext_r  <= 1'b0;
            keys_r <= 5'b00000;
        end else begin
            brk_r  <= brk_n;
            ext_r  <= ext_n;
            keys_r <= keys_n;
        end
    end

    // Scan-code decode: prefixes set flags, any other byte applies make/break then clears them.
    always_comb begin
        brk_n  = brk_r;
        ext_n  = ext_r;
        keys_n = keys_r;
        if (byte_done_s) begin
            if (byte_data_s == SC_BREAK) begin
                brk_n = 1'b1;
            end else if (byte_data_s == SC_EXT) begin
                ext_n = 1'b1;
            end else begin
                if (!ext_r) begin
                    case (byte_data_s)
                        SC_W:     keys_n[KEY_W]  = ~brk_r;
                        SC_A:     keys_n[KEY_A]  = ~brk_r;
                        SC_S:     keys_n[KEY_S]  = ~brk_r;
                        SC_D:     keys_n[KEY_D]  = ~brk_r;
                        SC_SPACE: keys_n[KEY_ST] = ~brk_r;
                        default:  keys_n = keys_r;
                    endcase
                end else begin
`ifdef PS2_ARROW_KEYS_EN
                    case (byte_data_s)
                        SC_UP:    keys_n[KEY_W] = ~brk_r;
                        SC_LEFT:  keys_n[KEY_A] = ~brk_r;
                        SC_DOWN:  keys_n[KEY_S] = ~brk_r;
                        SC_RIGHT: keys_n[KEY_D] = ~brk_r;
                        default:  keys_n = keys_r;
                    endcase
`else
                    keys_n = keys_r;
`endif
                end
                brk_n = 1'b0;
                ext_n = 1'b0;
            end
        end else begin
            keys_n = keys_r;
        end
    end

    assign key_w  = keys_r[KEY_W];
    assign key_a  = keys_r[KEY_A];
    assign key_s  = keys_r[KEY_S];
    assign key_d  = keys_r[KEY_D];
    assign key_st = keys_r[KEY_ST];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with a scaled PS/2 clock.
module tb_ps2_key_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 600;
    localparam int HP          = 40;
    localparam int EDGE_LAT    = SYNC_STAGES + FILTER_LEN;
`ifdef PS2_ARROW_KEYS_EN
    localparam logic ARROW = 1'b1;
`else
    localparam logic ARROW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;
    logic       key_w, key_a, key_s, key_d, key_st;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_cyc = 0;
    int err_cyc = 0;
    int last_fall = 0;
    logic [7:0] last_code = 8'h00;
    logic key_w_at_valid = 1'b0;
    logic both_seen = 1'b0;
    int exp_valid = 0;
    int exp_err = 0;

    ps2_key_decoder #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err),
        .key_w      (key_w),
        .key_a      (key_a),
        .key_s      (key_s),
        .key_d      (key_d),
        .key_st     (key_st)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (scan_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                last_code = scan_code;
                key_w_at_valid = key_w;
            end
            if (frame_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (scan_valid && frame_err) both_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        ps2_data = v;
        if (glitch) begin
            wait_cycles(HP / 2);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(HP / 2 - 3);
        end else begin
            wait_cycles(HP);
        end
        ps2_clk = 1'b0;
        last_fall = cyc;
        wait_cycles(HP);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of start/data/parity/stop, then idles the line.
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop,
                              input int nbits, input logic glitch);
        logic [10:0] bits;
        bits = {stop, (~(^b)) ^ flip_par, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
        ps2_data = 1'b1;
        wait_cycles(40);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0);
        exp_valid++;
    endtask

    initial begin
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        check("rst_scan_code", scan_code, 8'h00);
        check("rst_valid", scan_valid, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_keys", {key_w, key_a, key_s, key_d, key_st}, 5'b00000);
        rst = 1'b0;
        wait_cycles(20);

        send_good(8'h1D);
        check("w_valid_cnt", valid_cnt, exp_valid);
        check("w_code", last_code, 8'h1D);
        check("w_key", key_w, 1'b1);
        check("w_key_at_valid", key_w_at_valid, 1'b1);
        check("valid_latency", valid_cyc - last_fall, EDGE_LAT);

        send_good(8'h23);
        check("d_make", key_d, 1'b1);
        send_good(8'hF0);
        send_good(8'h1D);
        check("w_break", key_w, 1'b0);
        check("d_unchanged", key_d, 1'b1);
        check("brk_valid_cnt", valid_cnt, exp_valid);
        check("brk_code", last_code, 8'h1D);
        send_good(8'hF0);
        send_good(8'h23);
        check("d_break", key_d, 1'b0);

        send_frame(8'h29, 1'b1, 1'b1, 11, 1'b0);
        exp_err++;
        check("par_err_cnt", err_cnt, exp_err);
        check("par_no_valid", valid_cnt, exp_valid);
        check("par_key_st", key_st, 1'b0);

        send_frame(8'h23, 1'b0, 1'b0, 11, 1'b0);
        exp_err++;
        check("stop_err_cnt", err_cnt, exp_err);
        check("stop_key_d", key_d, 1'b0);
        check("stop_no_valid", valid_cnt, exp_valid);

        send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
        for (int i = 0; i < EDGE_LAT + TIMEOUT_CYC + 100; i++) begin
            if (err_cnt != exp_err) break;
            @(negedge clk);
        end
        exp_err++;
        check("tmo_err_cnt", err_cnt, exp_err);
        check("tmo_latency", err_cyc - last_fall, EDGE_LAT + TIMEOUT_CYC);
        send_good(8'h1C);
        check("a_make", key_a, 1'b1);
        check("a_valid_cnt", valid_cnt, exp_valid);

        send_frame(8'h1B, 1'b0, 1'b1, 11, 1'b1);
        exp_valid++;
        check("glitch_code", last_code, 8'h1B);
        check("glitch_key_s", key_s, 1'b1);
        check("glitch_valid_cnt", valid_cnt, exp_valid);
        check("glitch_err_cnt", err_cnt, exp_err);

        send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_keys", {key_w, key_a, key_s, key_d, key_st}, 5'b00000);
        check("midrst_code", scan_code, 8'h00);
        check("midrst_pulses", {scan_valid, frame_err}, 2'b00);
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(20);
        send_good(8'h29);
        check("post_rst_code", last_code, 8'h29);
        check("post_rst_st", key_st, 1'b1);
        check("post_rst_err", err_cnt, exp_err);

        send_good(8'hE0);
        send_good(8'h75);
        check("arrow_make", key_w, ARROW);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check("arrow_break", key_w, 1'b0);
        send_good(8'h1D);
        check("flags_cleared", key_w, 1'b1);
        check("final_valid_cnt", valid_cnt, exp_valid);
        check("never_both", both_seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
